ps2_keycode_rx: RTL and testbench

PS/2 keyboard receiver that deserialises device-clocked frames into scan-code bytes and resolves the E0 (extended) and F0 (break) prefixes. It drives `key_code` and a one-cycle `data_ready` strobe directly into the keycode store stage, which writes `{24'd0, key_code}` to data memory on every strobe. `key_code` therefore changes only together with a valid strobe.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_sync_edge.sv | 43 ++++
 rtl/ps2_keycode_rx.sv | 130 +++++++++++++
 tb/tb_ps2_keycode_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared receiver state encoding and PS/2 scan-code prefix bytes.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_edge
// Purpose  : Synchronises raw PS/2 clock/data and flags falling clock edges.
// Revision : 1.0
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    logic r_clk_s1;
    logic r_clk_s2;
    logic r_clk_prev;
    logic r_data_s1;
    logic r_data_s2;

    // Flops reset high to match the idle bus, so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data;
            r_data_s2  <= r_data_s1;
        end
    end

    assign fall   = r_clk_prev & ~r_clk_s2;
    assign data_s = r_data_s2;

endmodule
`default_nettype wire

// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keycode_rx
// Purpose  : PS/2 keyboard frame receiver with E0/F0 prefix resolution.
// Revision : 1.0
// ============================================================================
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000,
    parameter bit REPORT_BREAK   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       data_ready,
    output logic       key_release,
    output logic       key_extended,
    output logic       frame_err
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_max = c_cnt_w'(TIMEOUT_CYCLES);

    logic w_fall;
    logic w_data_s;
    logic w_frame_ok;
    logic w_timeout;

    ps2_state_t         r_state;
    logic [7:0]         r_shreg;
    logic [2:0]         r_bit_cnt;
    logic               r_parity;
    logic [c_cnt_w-1:0] r_tmo_cnt;
    logic               r_ext_pend;
    logic               r_brk_pend;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (w_fall),
        .data_s   (w_data_s)
    );

    // Evaluated on the stop-bit edge: stop must be 1 and parity odd over data+parity.
    assign w_frame_ok = w_data_s & (^r_shreg ^ r_parity);
    assign w_timeout  = (r_state != IDLE) && !w_fall && (r_tmo_cnt == c_tmo_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_parity     <= 1'b0;
            r_tmo_cnt    <= '0;
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            key_code     <= '0;
            data_ready   <= 1'b0;
            key_release  <= 1'b0;
            key_extended <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            frame_err  <= 1'b0;

            if (r_state == IDLE || w_fall) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_tmo_max) begin
                r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
            end

            if (w_timeout) begin
                r_state   <= IDLE;
                r_shreg   <= '0;
                r_bit_cnt <= '0;
                frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_data_s) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shreg   <= {w_data_s, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_data_s;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (!w_frame_ok) begin
                            frame_err  <= 1'b1;
                            r_ext_pend <= 1'b0;
                            r_brk_pend <= 1'b0;
                        end else if (r_shreg == PS2_EXT_PREFIX) begin
                            r_ext_pend <= 1'b1;
                        end else if (r_shreg == PS2_BRK_PREFIX) begin
                            r_brk_pend <= 1'b1;
                        end else begin
                            r_ext_pend <= 1'b0;
                            r_brk_pend <= 1'b0;
                            // Suppressed releases leave the previous report on the outputs.
                            if (!r_brk_pend || REPORT_BREAK) begin
                                key_code     <= r_shreg;
                                key_release  <= r_brk_pend;
                                key_extended <= r_ext_pend;
                                data_ready   <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keycode_rx
// Purpose  : Directed bench driving one RX with breaks suppressed, one reporting.
// Revision : 1.0
// ============================================================================
module tb_ps2_keycode_rx;

    localparam int c_tmo = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;

    logic [7:0] key0, key1;
    logic       dr0, rel0, ext0, err0;
    logic       dr1, rel1, ext1, err1;

    int nvec = 0;
    int nfail = 0;
    int dr_cnt0 = 0, err_cnt0 = 0, dr_cnt1 = 0, err_cnt1 = 0, both_cnt = 0;
    int s_dr0, s_err0, s_dr1, s_err1;

    ps2_keycode_rx #(.TIMEOUT_CYCLES(c_tmo), .REPORT_BREAK(1'b0)) u_rb0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_code     (key0),
        .data_ready   (dr0),
        .key_release  (rel0),
        .key_extended (ext0),
        .frame_err    (err0)
    );

    ps2_keycode_rx #(.TIMEOUT_CYCLES(c_tmo), .REPORT_BREAK(1'b1)) u_rb1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_code     (key1),
        .data_ready   (dr1),
        .key_release  (rel1),
        .key_extended (ext1),
        .frame_err    (err1)
    );

    always #5 clk = ~clk;

    // Counting high cycles: a correct one-cycle strobe adds exactly one per report.
    always @(negedge clk) begin
        if (dr0)  dr_cnt0  <= dr_cnt0 + 1;
        if (err0) err_cnt0 <= err_cnt0 + 1;
        if (dr1)  dr_cnt1  <= dr_cnt1 + 1;
        if (err1) err_cnt1 <= err_cnt1 + 1;
        if ((dr0 && err0) || (dr1 && err1)) both_cnt <= both_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_dr0 = dr_cnt0; s_err0 = err_cnt0; s_dr1 = dr_cnt1; s_err1 = err_cnt1;
    endtask

    task automatic deltas(input string tag, input int e_dr0, input int e_err0,
                          input int e_dr1, input int e_err1);
        checki({tag, "_dr0"},  dr_cnt0  - s_dr0,  e_dr0);
        checki({tag, "_err0"}, err_cnt0 - s_err0, e_err0);
        checki({tag, "_dr1"},  dr_cnt1  - s_dr1,  e_dr1);
        checki({tag, "_err1"}, err_cnt1 - s_err1, e_err1);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ par_flip);
        ps2_bit(stop_b);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check8("rst_key0", key0, 8'h00);  check1("rst_dr0", dr0, 1'b0);
        check1("rst_rel0", rel0, 1'b0);   check1("rst_ext0", ext0, 1'b0);
        check1("rst_err0", err0, 1'b0);   check8("rst_key1", key1, 8'h00);
        check1("rst_err1", err1, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Plain make code
        snap(); send_frame(8'h1C, 1'b0, 1'b1);
        deltas("make", 1, 0, 1, 0);
        check8("make_key0", key0, 8'h1C); check1("make_rel0", rel0, 1'b0);
        check1("make_ext0", ext0, 1'b0);  check8("make_key1", key1, 8'h1C);

        // Extended make
        snap(); send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'h75, 1'b0, 1'b1);
        deltas("ext", 1, 0, 1, 0);
        check8("ext_key0", key0, 8'h75);  check1("ext_ext0", ext0, 1'b1);
        check1("ext_rel0", rel0, 1'b0);   check1("ext_ext1", ext1, 1'b1);

        // Break: suppressed on rb0 (outputs held), reported on rb1
        snap(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h1C, 1'b0, 1'b1);
        deltas("brk", 0, 0, 1, 0);
        check8("brk_key0", key0, 8'h75);  check1("brk_ext0", ext0, 1'b1);
        check1("brk_rel0", rel0, 1'b0);   check8("brk_key1", key1, 8'h1C);
        check1("brk_rel1", rel1, 1'b1);   check1("brk_ext1", ext1, 1'b0);

        // Extended break
        snap();
        send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        deltas("xbrk", 0, 0, 1, 0);
        check8("xbrk_key1", key1, 8'h75); check1("xbrk_rel1", rel1, 1'b1);
        check1("xbrk_ext1", ext1, 1'b1);  check8("xbrk_key0", key0, 8'h75);

        // Prefix flags cleared after a suppressed release
        snap(); send_frame(8'h29, 1'b0, 1'b1);
        deltas("clr", 1, 0, 1, 0);
        check8("clr_key0", key0, 8'h29);  check1("clr_rel0", rel0, 1'b0);
        check1("clr_ext0", ext0, 1'b0);

        // Bad parity
        snap(); send_frame(8'h1C, 1'b1, 1'b1);
        deltas("par", 0, 1, 0, 1);
        check8("par_key0", key0, 8'h29);

        // Bad stop bit
        snap(); send_frame(8'h1C, 1'b0, 1'b0);
        deltas("stp", 0, 1, 0, 1);
        check8("stp_key0", key0, 8'h29);

        // A bad frame drops a pending E0
        snap();
        send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);
        deltas("perr_clr", 1, 1, 1, 1);
        check1("perr_clr_ext0", ext0, 1'b0);

        // Timeout on a truncated frame, then recovery
        send_frame(8'h1C, 1'b0, 1'b1);
        snap(); send_partial(8'h29, 4);
        repeat (c_tmo + 100) @(negedge clk);
        deltas("tmo", 0, 1, 0, 1);
        check8("tmo_key0", key0, 8'h1C);
        snap(); send_frame(8'h29, 1'b0, 1'b1);
        deltas("tmo_rec", 1, 0, 1, 0);
        check8("tmo_rec_key0", key0, 8'h29);

        // Reset mid-frame with ps2_clk held high
        send_partial(8'h1C, 4);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check8("mrst_key0", key0, 8'h00); check8("mrst_key1", key1, 8'h00);
        check1("mrst_dr0", dr0, 1'b0);    check1("mrst_rel1", rel1, 1'b0);
        check1("mrst_ext1", ext1, 1'b0);  check1("mrst_err0", err0, 1'b0);
        snap();
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        deltas("mrst_quiet", 0, 0, 0, 0);
        snap(); send_frame(8'h1C, 1'b0, 1'b1);
        deltas("mrst_rec", 1, 0, 1, 0);
        check8("mrst_rec_key0", key0, 8'h1C);
        check8("mrst_rec_key1", key1, 8'h1C);

        checki("dr_err_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
